// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the device-to-host packet framer.
// The header layout here is also what the host-side parser expects.
package usb_tx_pkg;

    localparam int          LenW         = 11;
    localparam logic [15:0] DefaultMagic = 16'hA55A;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HDR     = 2'd1,
        PAY     = 2'd2,
        TRL     = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [15:0]     magic;
        logic [3:0]      chan;
        logic            cont;
        logic [LenW-1:0] len;
    } tx_hdr_t;

endpackage

// File: rtl/usb_tx_buf.sv
// Payload store for one frame: simple dual-port RAM with a registered read port.
// Contents are deliberately not reset, so the array maps onto block or distributed RAM.
module usb_tx_buf #(
    parameter int Depth = 256,
    parameter int AddrW = $clog2(Depth)
) (
    input  logic             clk_sys,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  logic [31:0]      wr_data_i,
    input  logic             rd_en_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output logic [31:0]      rd_data_o
);

    logic [31:0] mem_q [Depth];
    logic [31:0] rd_data_q;

    // rd_data_q only changes on rd_en_i, which is what keeps a stalled payload word stable
    always_ff @(posedge clk_sys) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/usb_tx_framer.sv
// Store-and-forward framer: collects a packet, then emits header, payload and an
// xor checksum trailer. Packets longer than the buffer are split into continuation frames.
module usb_tx_framer
    import usb_tx_pkg::*;
#(
    parameter int          MaxPayloadWords = 256,
    parameter logic [15:0] Magic           = DefaultMagic
) (
    input  logic        clk_sys,
    input  logic        rst_req_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [3:0]  in_chan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [15:0] frame_count,
    output logic        seg_split_o
);

    localparam int              AddrW  = $clog2(MaxPayloadWords);
    localparam logic [LenW-1:0] MaxLen = LenW'(MaxPayloadWords);

    tx_state_e       state_q;
    logic [LenW-1:0] cnt_q;
    logic [LenW-1:0] idx_q;
    logic [31:0]     csum_q;
    logic [3:0]      chan_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [31:0]     out_data_q;
    logic            out_last_q;
    logic [15:0]     frame_count_q;
    logic            seg_split_q;

    logic            in_hs;
    logic            out_hs;
    logic [LenW-1:0] cnt_d;
    logic [LenW-1:0] idx_d;
    logic [3:0]      chan_d;
    logic            close_d;
    logic            last_word;
    tx_hdr_t         hdr_d;
    logic [31:0]     hdr_word;
    logic            rd_en;
    logic [AddrW-1:0] rd_addr;
    logic [31:0]     rd_data;

    assign in_hs     = in_valid && in_ready_q;
    assign out_hs    = out_valid_q && out_ready;
    assign cnt_d     = cnt_q + 1'b1;
    assign idx_d     = idx_q + 1'b1;
    assign chan_d    = (cnt_q == '0) ? in_chan : chan_q;
    assign close_d   = in_hs && (in_last || (cnt_d == MaxLen));
    assign last_word = (idx_q == (cnt_q - 1'b1));

    // A closing word without in_last can only mean the buffer filled up
    assign hdr_d    = '{magic: Magic, chan: chan_d, cont: !in_last, len: cnt_d};
    assign hdr_word = hdr_d;

    // Word 0 is fetched while the header is on the bus; later words are fetched on each payload handshake
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (state_q == HDR) begin
            rd_en = 1'b1;
        end else if (state_q == PAY) begin
            rd_en   = out_ready && !last_word;
            rd_addr = idx_d[AddrW-1:0];
        end
    end

    usb_tx_buf #(
        .Depth (MaxPayloadWords)
    ) u_buf (
        .clk_sys   (clk_sys),
        .wr_en_i   (in_hs),
        .wr_addr_i (cnt_q[AddrW-1:0]),
        .wr_data_i (in_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk_sys or negedge rst_req_n) begin
        if (!rst_req_n) begin
            state_q       <= COLLECT;
            cnt_q         <= '0;
            idx_q         <= '0;
            csum_q        <= '0;
            chan_q        <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            frame_count_q <= '0;
            seg_split_q   <= 1'b0;
        end else begin
            seg_split_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (in_hs) begin
                        cnt_q  <= cnt_d;
                        chan_q <= chan_d;
                        if (close_d) begin
                            state_q     <= HDR;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= hdr_word;
                            out_last_q  <= 1'b0;
                            csum_q      <= csum_q ^ in_data ^ hdr_word;
                            seg_split_q <= !in_last;
                        end else begin
                            csum_q <= csum_q ^ in_data;
                        end
                    end
                end
                HDR: begin
                    if (out_hs) begin
                        state_q <= PAY;
                        idx_q   <= '0;
                    end
                end
                PAY: begin
                    if (out_hs) begin
                        if (last_word) begin
                            state_q    <= TRL;
                            out_data_q <= csum_q;
                            out_last_q <= 1'b1;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                TRL: begin
                    if (out_hs) begin
                        state_q       <= COLLECT;
                        out_valid_q   <= 1'b0;
                        out_last_q    <= 1'b0;
                        out_data_q    <= '0;
                        cnt_q         <= '0;
                        csum_q        <= '0;
                        in_ready_q    <= 1'b1;
                        frame_count_q <= frame_count_q + 16'd1;
                    end
                end
                default: begin
                    state_q     <= COLLECT;
                    cnt_q       <= '0;
                    csum_q      <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = (state_q == PAY) ? rd_data : out_data_q;
    assign out_last    = out_last_q;
    assign frame_count = frame_count_q;
    assign seg_split_o = seg_split_q;

endmodule

// File: tb/tb_usb_tx_framer.sv
// Directed bench for usb_tx_framer: a 256-deep instance for most scenarios and a
// 4-deep instance for packet splitting.
module tb_usb_tx_framer;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        rst_req_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last, seg_split;
    logic [31:0] in_data, out_data;
    logic [3:0]  in_chan;
    logic [15:0] frame_count;

    logic        in_valid4, in_ready4, in_last4, out_valid4, out_ready4, out_last4, seg_split4;
    logic [31:0] in_data4, out_data4;
    logic [3:0]  in_chan4;
    logic [15:0] frame_count4;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_d [$];
    logic        got_l [$];
    logic [31:0] exp_d [$];

    usb_tx_framer dut (
        .clk_sys(clk_sys), .rst_req_n(rst_req_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .in_chan(in_chan),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_count(frame_count), .seg_split_o(seg_split)
    );

    usb_tx_framer #(.MaxPayloadWords(4)) dut4 (
        .clk_sys(clk_sys), .rst_req_n(rst_req_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4), .in_chan(in_chan4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_last(out_last4),
        .frame_count(frame_count4), .seg_split_o(seg_split4)
    );

    function automatic logic [31:0] hdr_of(input logic [3:0] ch, input logic cont, input int len);
        return {16'hA55A, ch, cont, 11'(len)};
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last, input logic [3:0] ch);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = last; in_chan = ch;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk_sys); #1; n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk_sys); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Captures handshaken words until the trailer, checking that stalled outputs hold
    task automatic collect(input int pct, output bit to, output int cyc);
        bit          prev_stall = 1'b0;
        bit          done = 1'b0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        int          c = 0;
        got_d.delete(); got_l.delete();
        while (!done && c < 1000) begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    errors++;
                    $display("FAIL stall_hold valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                             out_valid, out_data, out_last, pd, pl);
                end
            end
            out_ready = ($urandom_range(0, 99) < pct);
            pd = out_data; pl = out_last;
            prev_stall = out_valid && !out_ready;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                done = out_last;
            end
            @(posedge clk_sys); #1; c++;
        end
        out_ready = 1'b0;
        to = !done;
        cyc = c;
    endtask

    task automatic test_reset();
        rst_req_n = 1'b0;
        in_valid = 0; in_data = 0; in_last = 0; in_chan = 0; out_ready = 0;
        in_valid4 = 0; in_data4 = 0; in_last4 = 0; in_chan4 = 0; out_ready4 = 0;
        repeat (2) @(posedge clk_sys);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0 ||
            frame_count !== 16'h0 || seg_split !== 1'b0) begin
            errors++;
            $display("FAIL reset_state in_ready=%b out_valid=%b out_data=%h out_last=%b fc=%h split=%b required 1 0 0 0 0 0",
                     in_ready, out_valid, out_data, out_last, frame_count, seg_split);
        end
        rst_req_n = 1'b1;
        @(posedge clk_sys); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release in_ready=%b out_valid=%b in_ready4=%b out_valid4=%b required 1 0 1 0",
                     in_ready, out_valid, in_ready4, out_valid4);
        end
        $display("reset: in_ready=%b out_valid=%b frame_count=%0d", in_ready, out_valid, frame_count);
    endtask

    task automatic test_three_word();
        bit to;
        int cyc;
        send_word(32'h11111111, 1'b0, 4'd2);
        send_word(32'h22222222, 1'b0, 4'd2);
        send_word(32'h44444444, 1'b1, 4'd2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA55A2003 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL three_hdr_latency valid=%b data=%h in_ready=%b required 1 a55a2003 0",
                     out_valid, out_data, in_ready);
        end
        exp_d = '{32'hA55A2003, 32'h11111111, 32'h22222222, 32'h44444444, 32'hD22D5774};
        collect(100, to, cyc);
        checks++;
        if (to || got_d.size() != exp_d.size() || cyc != 5) begin
            errors++;
            $display("FAIL three_len words=%0d cycles=%0d required 5 5", got_d.size(), cyc);
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1)) begin
                errors++;
                $display("FAIL three_word[%0d] data=%h last=%b required %h %b", i, got_d[i], got_l[i],
                         exp_d[i], i == exp_d.size() - 1);
            end
        end
        checks++;
        if (frame_count !== 16'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL three_count fc=%0d in_ready=%b required 1 1", frame_count, in_ready);
        end
        $display("three_word: %0d words out, frame_count=%0d", got_d.size(), frame_count);
    endtask

    task automatic test_single_word();
        logic [31:0] exp_w [3];
        int          zeros = 0;
        exp_w = '{32'hA55A0001, 32'h00000000, 32'hA55A0001};
        send_word(32'h0, 1'b1, 4'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (in_ready === 1'b0) zeros++;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w[i] || out_last !== (i == 2)) begin
                errors++;
                $display("FAIL single_word[%0d] valid=%b data=%h last=%b required 1 %h %b",
                         i, out_valid, out_data, out_last, exp_w[i], i == 2);
            end
            @(posedge clk_sys); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (zeros != 3 || in_ready !== 1'b1 || out_valid !== 1'b0 || frame_count !== 16'd2) begin
            errors++;
            $display("FAIL single_busy busy=%0d in_ready=%b valid=%b fc=%0d required 3 1 0 2",
                     zeros, in_ready, out_valid, frame_count);
        end
        $display("single_word: busy cycles=%0d frame_count=%0d", zeros, frame_count);
    endtask

    task automatic test_split();
        logic [31:0] w [6];
        logic [31:0] cs;
        logic [31:0] gd [$];
        logic        gl [$];
        int          splits = 0;
        int          frames = 0;
        int          stuck = 0;
        w = '{32'h01010101, 32'h02020202, 32'h04040404, 32'h08080808, 32'h10101010, 32'h20202020};
        exp_d.delete();
        cs = hdr_of(4'd0, 1'b1, 4);
        exp_d.push_back(cs);
        for (int i = 0; i < 4; i++) begin exp_d.push_back(w[i]); cs ^= w[i]; end
        exp_d.push_back(cs);
        cs = hdr_of(4'd0, 1'b0, 2);
        exp_d.push_back(cs);
        for (int i = 4; i < 6; i++) begin exp_d.push_back(w[i]); cs ^= w[i]; end
        exp_d.push_back(cs);
        out_ready4 = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int n = 0;
                    in_valid4 = 1'b1; in_data4 = w[i]; in_last4 = (i == 5); in_chan4 = 4'd0;
                    while (in_ready4 !== 1'b1 && n < 100) begin @(posedge clk_sys); #1; n++; end
                    if (n >= 100) stuck++;
                    @(posedge clk_sys); #1;
                end
                in_valid4 = 1'b0; in_last4 = 1'b0;
            end
            begin
                for (int c = 0; c < 200 && frames < 2; c++) begin
                    if (seg_split4 === 1'b1) splits++;
                    if (out_valid4 && out_ready4) begin
                        gd.push_back(out_data4);
                        gl.push_back(out_last4);
                        if (out_last4) frames++;
                    end
                    @(posedge clk_sys); #1;
                end
            end
        join
        out_ready4 = 1'b0;
        checks++;
        if (stuck != 0 || gd.size() != exp_d.size() || splits != 1 || frame_count4 !== 16'd2) begin
            errors++;
            $display("FAIL split_summary stuck=%0d words=%0d splits=%0d fc=%0d required 0 %0d 1 2",
                     stuck, gd.size(), splits, frame_count4, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < gd.size(); i++) begin
            checks++;
            if (gd[i] !== exp_d[i] || gl[i] !== (i == 5 || i == 9)) begin
                errors++;
                $display("FAIL split_word[%0d] data=%h last=%b required %h %b", i, gd[i], gl[i],
                         exp_d[i], i == 5 || i == 9);
            end
        end
        $display("split: %0d words, %0d split pulses, frame_count=%0d", gd.size(), splits, frame_count4);
    endtask

    task automatic test_random_stall();
        int          lens [3];
        logic [3:0]  chans [3];
        logic [31:0] cs, wd;
        bit          to;
        int          cyc;
        lens = '{5, 1, 8};
        chans = '{4'd7, 4'd15, 4'd9};
        for (int p = 0; p < 3; p++) begin
            exp_d.delete();
            cs = hdr_of(chans[p], 1'b0, lens[p]);
            exp_d.push_back(cs);
            for (int i = 0; i < lens[p]; i++) begin
                wd = $urandom;
                exp_d.push_back(wd);
                cs ^= wd;
                send_word(wd, i == lens[p] - 1, chans[p]);
            end
            exp_d.push_back(cs);
            collect(30, to, cyc);
            checks++;
            if (to || got_d.size() != exp_d.size()) begin
                errors++;
                $display("FAIL stall_len pkt=%0d words=%0d required %0d", p, got_d.size(), exp_d.size());
            end
            for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
                checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1)) begin
                    errors++;
                    $display("FAIL stall_word pkt=%0d [%0d] data=%h last=%b required %h %b", p, i,
                             got_d[i], got_l[i], exp_d[i], i == exp_d.size() - 1);
                end
            end
            $display("random_stall pkt %0d: len=%0d, %0d words out in %0d cycles", p, lens[p], got_d.size(), cyc);
        end
        checks++;
        if (frame_count !== 16'd5) begin
            errors++;
            $display("FAIL stall_count fc=%0d required 5", frame_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int cyc;
        for (int i = 0; i < 4; i++) send_word(32'hAAAA0000 + 32'(i), i == 3, 4'd5);
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk_sys); #1; end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hAAAA0002) begin
            errors++;
            $display("FAIL abort_pre valid=%b data=%h required 1 aaaa0002", out_valid, out_data);
        end
        rst_req_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || frame_count !== 16'd0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset valid=%b fc=%0d in_ready=%b data=%h last=%b required 0 0 1 0 0",
                     out_valid, frame_count, in_ready, out_data, out_last);
        end
        @(posedge clk_sys); #1;
        rst_req_n = 1'b1;
        out_ready = 1'b0;
        @(posedge clk_sys); #1;
        send_word(32'hCAFEBABE, 1'b0, 4'd3);
        send_word(32'h12345678, 1'b1, 4'd3);
        exp_d = '{32'hA55A3002, 32'hCAFEBABE, 32'h12345678, 32'hA55A3002 ^ 32'hCAFEBABE ^ 32'h12345678};
        collect(100, to, cyc);
        checks++;
        if (to || got_d.size() != exp_d.size() || frame_count !== 16'd1) begin
            errors++;
            $display("FAIL abort_next_len words=%0d fc=%0d required 4 1", got_d.size(), frame_count);
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 3)) begin
                errors++;
                $display("FAIL abort_next[%0d] data=%h last=%b required %h %b", i, got_d[i], got_l[i], exp_d[i], i == 3);
            end
        end
        $display("reset_mid_frame: next frame %0d words, frame_count=%0d", got_d.size(), frame_count);
    endtask

    task automatic test_frame_count_wrap();
        bit to;
        int cyc;
        force dut.frame_count_q = 16'hFFFF;
        @(posedge clk_sys); #1;
        release dut.frame_count_q;
        checks++;
        if (frame_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload fc=%h required ffff", frame_count);
        end
        send_word(32'h00000005, 1'b1, 4'd1);
        collect(100, to, cyc);
        checks++;
        if (to || got_d.size() != 3 || frame_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_count words=%0d fc=%h required 3 0000", got_d.size(), frame_count);
        end
        $display("frame_count_wrap: frame_count=%h", frame_count);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_three_word();
        test_single_word();
        test_split();
        test_random_stall();
        test_reset_mid_frame();
        test_frame_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
